// File: rtl/raster_pkg.sv
// Shared constants, coordinate type and FSM encoding for the line rasterizer.
package raster_pkg;
    localparam int COORD_W  = 11;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ADDR_W   = 19;

    // Deltas carry one extra bit so |dx| never hits the most-negative value.
    localparam int DELTA_W  = COORD_W + 1;
    // Accumulator holds acc+minor < 2*major without overflow.
    localparam int ACC_W    = COORD_W + 2;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;
endpackage

// File: rtl/abs_val.sv
// Two's-complement absolute value; the most-negative input wraps to itself.
module abs_val #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] valIn,
    output logic [WIDTH-1:0] valOut
);
    assign valOut = valIn[WIDTH-1] ? (~valIn) + WIDTH'(1) : valIn;
endmodule

// File: rtl/bresenham_core.sv
// Bresenham error accumulator: signals a minor-axis step each time the
// running sum of minor deltas crosses the major delta.
module bresenham_core
    import raster_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DELTA_W-1:0] numerator,
    input  logic [DELTA_W-1:0] denominator,
    output logic               inc
);
    logic [ACC_W-1:0] acc_q, acc_d, sum;

    // Next accumulator value and the step decision for this cycle.
    always_comb begin
        sum   = acc_q + ACC_W'(numerator);
        acc_d = acc_q;
        inc   = 1'b0;
        if (en) begin
            if (sum >= ACC_W'(denominator)) begin
                inc   = 1'b1;
                acc_d = sum - ACC_W'(denominator);
            end else begin
                acc_d = sum;
            end
        end
    end

    // Reset/load centres the error term at half the major delta.
    always_ff @(posedge clk) begin
        if (rst) acc_q <= ACC_W'(denominator >> 1);
        else     acc_q <= acc_d;
    end
endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: one candidate pixel per clock with its
// framebuffer address and an on-screen flag.
module line_rasterizer
    import raster_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [COORD_W-1:0] startX,
    input  logic signed [COORD_W-1:0] startY,
    input  logic signed [COORD_W-1:0] endX,
    input  logic signed [COORD_W-1:0] endY,
    input  logic                      readyIn,
    output logic signed [COORD_W-1:0] pixelX,
    output logic signed [COORD_W-1:0] pixelY,
    output logic [ADDR_W-1:0]         addressOut,
    output logic                      goodPixel,
    output logic                      done
);
    state_t state_q, state_d;
    coord_t start_x_q, start_x_d, start_y_q, start_y_d;
    coord_t end_x_q, end_x_d, end_y_q, end_y_d;
    coord_t pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    coord_t step_x_q, step_x_d, step_y_q, step_y_d;
    logic   steep_q, steep_d;
    logic [DELTA_W-1:0] major_q, major_d, minor_q, minor_d;
    logic [DELTA_W-1:0] remaining_q, remaining_d;

    logic [DELTA_W-1:0] dx, dy, adx, ady, major_c, minor_c;
    coord_t sx_c, sy_c;
    logic   steep_c, load, core_rst, core_en, inc, on_screen;
    logic [DELTA_W-1:0] core_num, core_den;

    abs_val #(.WIDTH(DELTA_W)) u_abs_x (.valIn(dx), .valOut(adx));
    abs_val #(.WIDTH(DELTA_W)) u_abs_y (.valIn(dy), .valOut(ady));

    // Line geometry derived from the latched endpoints, used during SETUP.
    always_comb begin
        dx      = {end_x_q[COORD_W-1], end_x_q} - {start_x_q[COORD_W-1], start_x_q};
        dy      = {end_y_q[COORD_W-1], end_y_q} - {start_y_q[COORD_W-1], start_y_q};
        sx_c    = (dx == '0) ? '0 : (dx[DELTA_W-1] ? '1 : COORD_W'(1));
        sy_c    = (dy == '0) ? '0 : (dy[DELTA_W-1] ? '1 : COORD_W'(1));
        steep_c = ady > adx;
        major_c = steep_c ? ady : adx;
        minor_c = steep_c ? adx : ady;
    end

    // The core sees live geometry while loading, latched geometry afterwards.
    assign load     = (state_q == SETUP);
    assign core_rst = rst | load;
    assign core_en  = (state_q == DRAW) && (remaining_q != '0);
    assign core_num = load ? minor_c : minor_q;
    assign core_den = load ? major_c : major_q;

    bresenham_core u_core (
        .clk        (clk),
        .rst        (core_rst),
        .en         (core_en),
        .numerator  (core_num),
        .denominator(core_den),
        .inc        (inc)
    );

    // Next-state and datapath updates for the IDLE/SETUP/DRAW/FINISH sequence.
    always_comb begin
        state_d     = state_q;
        start_x_d   = start_x_q;
        start_y_d   = start_y_q;
        end_x_d     = end_x_q;
        end_y_d     = end_y_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        step_x_d    = step_x_q;
        step_y_d    = step_y_q;
        steep_d     = steep_q;
        major_d     = major_q;
        minor_d     = minor_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (readyIn) begin
                    start_x_d = startX;
                    start_y_d = startY;
                    end_x_d   = endX;
                    end_y_d   = endY;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                pix_x_d     = start_x_q;
                pix_y_d     = start_y_q;
                step_x_d    = sx_c;
                step_y_d    = sy_c;
                steep_d     = steep_c;
                major_d     = major_c;
                minor_d     = minor_c;
                remaining_d = major_c;
                state_d     = DRAW;
            end
            DRAW: begin
                if (remaining_q == '0) begin
                    state_d = FINISH;
                end else begin
                    remaining_d = remaining_q - DELTA_W'(1);
                    if (steep_q) begin
                        pix_y_d = pix_y_q + step_y_q;
                        if (inc) pix_x_d = pix_x_q + step_x_q;
                    end else begin
                        pix_x_d = pix_x_q + step_x_q;
                        if (inc) pix_y_d = pix_y_q + step_y_q;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_x_q   <= '0;
            start_y_q   <= '0;
            end_x_q     <= '0;
            end_y_q     <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            step_x_q    <= '0;
            step_y_q    <= '0;
            steep_q     <= 1'b0;
            major_q     <= '0;
            minor_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            start_x_q   <= start_x_d;
            start_y_q   <= start_y_d;
            end_x_q     <= end_x_d;
            end_y_q     <= end_y_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            step_x_q    <= step_x_d;
            step_y_q    <= step_y_d;
            steep_q     <= steep_d;
            major_q     <= major_d;
            minor_q     <= minor_d;
            remaining_q <= remaining_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        on_screen  = !pix_x_q[COORD_W-1] && (pix_x_q < coord_t'(SCREEN_W)) &&
                     !pix_y_q[COORD_W-1] && (pix_y_q < coord_t'(SCREEN_H));
        goodPixel  = (state_q == DRAW) && on_screen;
        addressOut = goodPixel ?
                     ADDR_W'($unsigned(pix_y_q)) * ADDR_W'(SCREEN_W) + ADDR_W'($unsigned(pix_x_q)) :
                     '0;
        pixelX     = pix_x_q;
        pixelY     = pix_y_q;
        done       = (state_q == FINISH);
    end
endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench: directed and random lines against a closed-form
// Bresenham model (minor offset = floor((i*minor + major/2) / major)).
module tb_line_rasterizer;
    import raster_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [COORD_W-1:0] startX = '0, startY = '0, endX = '0, endY = '0;
    logic readyIn = 1'b0;
    logic signed [COORD_W-1:0] pixelX, pixelY;
    logic [ADDR_W-1:0] addressOut;
    logic goodPixel, done;

    int n_vec = 0;
    int n_err = 0;

    line_rasterizer dut (
        .clk(clk), .rst(rst),
        .startX(startX), .startY(startY), .endX(endX), .endY(endY),
        .readyIn(readyIn),
        .pixelX(pixelX), .pixelY(pixelY),
        .addressOut(addressOut), .goodPixel(goodPixel), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Draw one line and check every emitted pixel plus the done pulse.
    // With poke set, a second readyIn with other coordinates lands in SETUP.
    task automatic run_line(input int x0, input int y0, input int x1, input int y1, input bit poke);
        int dx, dy, maj, mnr, off, ex, ey, eaddr;
        bit steep, good;
        dx = x1 - x0; dy = y1 - y0;
        steep = iabs(dy) > iabs(dx);
        maj = steep ? iabs(dy) : iabs(dx);
        mnr = steep ? iabs(dx) : iabs(dy);

        @(negedge clk);
        startX = COORD_W'(x0); startY = COORD_W'(y0);
        endX = COORD_W'(x1); endY = COORD_W'(y1);
        readyIn = 1'b1;
        @(negedge clk);
        readyIn = 1'b0;
        if (poke) begin
            readyIn = 1'b1;
            startX = COORD_W'(300); startY = COORD_W'(300);
            endX = COORD_W'(310); endY = COORD_W'(320);
        end
        chk("setup_good", goodPixel, 0);
        chk("setup_done", done, 0);
        @(negedge clk);
        readyIn = 1'b0;
        for (int i = 0; i <= maj; i++) begin
            off = (maj == 0) ? 0 : (i * mnr + maj / 2) / maj;
            if (steep) begin
                ey = y0 + sgn(dy) * i;
                ex = x0 + sgn(dx) * off;
            end else begin
                ex = x0 + sgn(dx) * i;
                ey = y0 + sgn(dy) * off;
            end
            good  = (ex >= 0) && (ex < SCREEN_W) && (ey >= 0) && (ey < SCREEN_H);
            eaddr = good ? ey * SCREEN_W + ex : 0;
            chk("pix_x", pixelX, ex);
            chk("pix_y", pixelY, ey);
            chk("pix_good", goodPixel, good);
            chk("pix_addr", addressOut, eaddr);
            chk("pix_nodone", done, 0);
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        chk("done_good", goodPixel, 0);
        @(negedge clk);
        chk("done_clear", done, 0);
    endtask

    initial begin
        int x0, y0, x1, y1;
        // Reset and idle behaviour
        @(negedge clk);
        @(negedge clk);
        chk("rst_good", goodPixel, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", addressOut, 0);
        chk("rst_x", pixelX, 0);
        chk("rst_y", pixelY, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_good", goodPixel, 0);
            chk("idle_done", done, 0);
        end

        // Directed lines
        run_line(0, 0, 3, 0, 1'b0);
        run_line(-25, 50, 75, 250, 1'b0);
        run_line(10, 10, 10, 10, 1'b1);
        run_line(5, 5, 0, 2, 1'b0);
        run_line(700, 500, 702, 500, 1'b0);
        run_line(639, 479, 639, 479, 1'b0);

        // Reset in the middle of a 100-pixel line
        @(negedge clk);
        startX = '0; startY = '0; endX = COORD_W'(99); endY = '0;
        readyIn = 1'b1;
        @(negedge clk);
        readyIn = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_good", goodPixel, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_good", goodPixel, 0);
        chk("abort_done", done, 0);
        chk("abort_x", pixelX, 0);
        chk("abort_addr", addressOut, 0);
        for (int i = 0; i < 110; i++) begin
            chk("abort_nodone", done, 0);
            @(negedge clk);
        end
        run_line(20, 30, 27, 33, 1'b0);

        // Random short lines around and beyond the screen edges
        for (int k = 0; k < 30; k++) begin
            x0 = int'($urandom_range(840)) - 100;
            y0 = int'($urandom_range(680)) - 100;
            x1 = x0 + int'($urandom_range(120)) - 60;
            y1 = y0 + int'($urandom_range(120)) - 60;
            run_line(x0, y0, x1, y1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
